// File: rtl/irq_relay.sv
// irq_relay: loopback channel between a CPU model's IRQ output and IRQ input.
// Every change on i_irq is captured into a FIFO in order. The changes are
// replayed on o_irq, and consecutive output values are kept at least MIN_HOLD
// cycles apart.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   MIN_HOLD   minimum cycles each emitted value stays on o_irq (>= 1)
// Ports
//   clk        single clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   i_irq      IRQ word from the producer
//   i_stall    blocks new emissions while high; capture continues
//   o_irq      replayed IRQ word
//   o_level    FIFO occupancy, 0..DEPTH
//   o_count    number of values emitted since reset (wraps)
//   o_overflow sticky, set when a change is dropped on a full FIFO
//
// Emit FSM
//   state | meaning
//   IDLE  | may pop the head onto o_irq when FIFO not empty and not stalled
//   HOLD  | holding the last emitted value until hold_cnt reaches 0
module irq_relay #(
  parameter int DEPTH    = 8,
  parameter int MIN_HOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                i_irq,
  input  logic                       i_stall,
  output logic [31:0]                o_irq,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [31:0]                o_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [31:0]     last_in;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            change;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            drop;

  always_comb begin
    change     = (i_irq != last_in);
    fifo_empty = (o_level == '0);
    fifo_full  = (o_level == FULL_LVL);
    pop        = (state == IDLE) && !fifo_empty && !i_stall;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = change && (!fifo_full || pop);
    drop       = change && fifo_full && !pop;
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_irq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_in    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (change) begin
        last_in <= i_irq;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        o_level <= o_level + LW'(1);
      end else if (pop && !push) begin
        o_level <= o_level - LW'(1);
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      o_irq    <= '0;
      o_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            // When full and pushing this cycle, the write lands on the same
            // slot; the non-blocking write leaves the old head readable here.
            o_irq   <= mem[rd_ptr];
            o_count <= o_count + 32'd1;
            if (MIN_HOLD > 1) begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - HW'(1);
          if (hold_cnt == HW'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_relay.sv
// Directed bench for irq_relay: four instances with different DEPTH/MIN_HOLD
// share one clock and reset; each scenario drives one instance.
module tb_irq_relay;

  logic clk;
  logic rst_n;

  logic [31:0] irq_a, irq_b, irq_c, irq_d;
  logic        stall_a, stall_b, stall_c, stall_d;

  logic [31:0] oirq_a, oirq_b, oirq_c, oirq_d;
  logic [3:0]  lvl_a, lvl_b;
  logic [2:0]  lvl_c, lvl_d;
  logic [31:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;

  int n_chk;
  int n_pass;

  irq_relay #(.DEPTH(8), .MIN_HOLD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .i_irq(irq_a), .i_stall(stall_a),
    .o_irq(oirq_a), .o_level(lvl_a), .o_count(cnt_a), .o_overflow(ovf_a));

  irq_relay #(.DEPTH(8), .MIN_HOLD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .i_irq(irq_b), .i_stall(stall_b),
    .o_irq(oirq_b), .o_level(lvl_b), .o_count(cnt_b), .o_overflow(ovf_b));

  irq_relay #(.DEPTH(4), .MIN_HOLD(8)) u_c (
    .clk(clk), .rst_n(rst_n), .i_irq(irq_c), .i_stall(stall_c),
    .o_irq(oirq_c), .o_level(lvl_c), .o_count(cnt_c), .o_overflow(ovf_c));

  irq_relay #(.DEPTH(4), .MIN_HOLD(1)) u_d (
    .clk(clk), .rst_n(rst_n), .i_irq(irq_d), .i_stall(stall_d),
    .o_irq(oirq_d), .o_level(lvl_d), .o_count(cnt_d), .o_overflow(ovf_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq_a = '0; irq_b = '0; irq_c = '0; irq_d = '0;
    stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0; stall_d = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [31:0] exp_irq_b [12] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4};
  logic [31:0] exp_lvl_b [12] = '{1, 1, 2, 3, 2, 2, 2, 1, 1, 1, 0, 0};

  initial begin
    logic [31:0] seen [$];
    int          t_seen [$];
    logic [31:0] prev;
    logic [31:0] v;

    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;
    #2;
    do_reset();

    // Reset state
    chk("rst_irq", oirq_a, 32'h0);
    chk("rst_lvl", 32'(lvl_a), 32'd0);
    chk("rst_cnt", cnt_a, 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);

    // Single change, MIN_HOLD=1: one cycle of latency
    irq_a = 32'h1234_5678;
    step();
    chk("single_lvl_push", 32'(lvl_a), 32'd1);
    chk("single_irq_early", oirq_a, 32'h0);
    step();
    chk("single_irq", oirq_a, 32'h1234_5678);
    chk("single_cnt", cnt_a, 32'd1);
    chk("single_lvl_pop", 32'(lvl_a), 32'd0);

    // Burst, MIN_HOLD=3: updates exactly 3 cycles apart, peak level 3
    for (int i = 0; i < 12; i++) begin
      if (i < 4) irq_b = 32'(i + 1);
      step();
      chk($sformatf("burst_irq_%0d", i), oirq_b, exp_irq_b[i]);
      chk($sformatf("burst_lvl_%0d", i), 32'(lvl_b), exp_lvl_b[i]);
    end
    chk("burst_cnt", cnt_b, 32'd4);
    chk("burst_ovf", 32'(ovf_b), 32'd0);

    // Overflow, DEPTH=4 MIN_HOLD=8: value 6 is dropped
    for (int i = 1; i <= 6; i++) begin
      irq_c = 32'(i);
      step();
    end
    chk("ovf_lvl_full", 32'(lvl_c), 32'd4);
    chk("ovf_flag", 32'(ovf_c), 32'd1);
    chk("ovf_first", oirq_c, 32'd1);
    prev = oirq_c;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (oirq_c !== prev) begin
        seen.push_back(oirq_c);
        t_seen.push_back(k);
        prev = oirq_c;
      end
    end
    chk("ovf_nemit", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      v = (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF;
      chk($sformatf("ovf_seq_%0d", i), v, 32'(i + 2));
    end
    if (t_seen.size() >= 2) begin
      chk("ovf_spacing", 32'(t_seen[1] - t_seen[0]), 32'd8);
    end else begin
      chk("ovf_spacing_missing", 32'(t_seen.size()), 32'd2);
    end
    chk("ovf_cnt", cnt_c, 32'd5);
    chk("ovf_sticky", 32'(ovf_c), 32'd1);
    chk("ovf_lvl_end", 32'(lvl_c), 32'd0);

    // Stall then full FIFO with simultaneous push and pop
    do_reset();
    chk("rst_ovf_c", 32'(ovf_c), 32'd0);
    stall_d = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      irq_d = 32'(i);
      step();
    end
    chk("stall_lvl", 32'(lvl_d), 32'd4);
    chk("stall_irq", oirq_d, 32'h0);
    chk("stall_cnt", cnt_d, 32'd0);
    stall_d = 1'b0;
    irq_d   = 32'd5;
    step();
    chk("fullpop_lvl", 32'(lvl_d), 32'd4);
    chk("fullpop_ovf", 32'(ovf_d), 32'd0);
    chk("fullpop_irq", oirq_d, 32'd1);
    step();
    chk("drain_irq2", oirq_d, 32'd2);
    step();
    step();
    step();
    chk("drain_irq5", oirq_d, 32'd5);
    chk("drain_lvl", 32'(lvl_d), 32'd0);
    chk("drain_cnt", cnt_d, 32'd5);

    // Reset mid-operation: 3 entries buffered while in HOLD
    do_reset();
    for (int i = 0; i < 5; i++) begin
      irq_b = 32'(10 + i);
      step();
    end
    chk("midrst_lvl_pre", 32'(lvl_b), 32'd3);
    chk("midrst_irq_pre", oirq_b, 32'd11);
    #2;
    rst_n = 1'b0;
    irq_b = '0;
    #1;
    chk("midrst_irq", oirq_b, 32'h0);
    chk("midrst_lvl", 32'(lvl_b), 32'd0);
    chk("midrst_cnt", cnt_b, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    irq_b = 32'h55;
    step();
    chk("postrst_lvl", 32'(lvl_b), 32'd1);
    chk("postrst_irq_early", oirq_b, 32'h0);
    step();
    chk("postrst_irq", oirq_b, 32'h55);
    chk("postrst_cnt", cnt_b, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
